// File: rtl/encoder_4to2_pkg.sv
// Shared types and code constants for the registered 4-to-2 priority encoder.
// The state enum and code constants are shared by the core and the registered top.
package encoder_4to2_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [1:0] CODE_D0 = 2'b00;
  localparam logic [1:0] CODE_D1 = 2'b01;
  localparam logic [1:0] CODE_D2 = 2'b10;
  localparam logic [1:0] CODE_D3 = 2'b11;

endpackage

// File: rtl/encoder_4to2_core.sv
// Combinational priority encoder: four request lines to a 2-bit index,
// plus flags for words that are not one-hot.
module encoder_4to2_core
  import encoder_4to2_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic [3:0] d,
  output logic [1:0] code,
  output logic       multi,
  output logic       none
);

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    code = CODE_D0;
    if (PRIORITY_HIGH) begin
      if      (d[3]) code = CODE_D3;
      else if (d[2]) code = CODE_D2;
      else if (d[1]) code = CODE_D1;
      else           code = CODE_D0;
    end else begin
      if      (d[0]) code = CODE_D0;
      else if (d[1]) code = CODE_D1;
      else if (d[2]) code = CODE_D2;
      else if (d[3]) code = CODE_D3;
      else           code = CODE_D0;
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign none  = (d == 4'b0000);
  assign multi = ((d & (d - 4'd1)) != 4'b0000);

endmodule

// File: rtl/encoder_4to2_reg.sv
// Registered 4-to-2 priority encoder with valid/ready handshake on both sides
// and a saturating count of accepted words that were not one-hot.
module encoder_4to2_reg
  import encoder_4to2_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 D0,
  input  logic                 D1,
  input  logic                 D2,
  input  logic                 D3,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 A0,
  output logic                 A1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 multi_err,
  output logic                 none_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_t     state;
  logic       accept;
  logic [1:0] code;
  logic       multi;
  logic       none;

  encoder_4to2_core #(
    .PRIORITY_HIGH (PRIORITY_HIGH)
  ) u_core (
    .d     ({D3, D2, D1, D0}),
    .code  (code),
    .multi (multi),
    .none  (none)
  );

  // A full slot can still take a word when the consumer drains it this cycle.
  assign in_ready  = (state == ST_EMPTY) || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_FULL);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      A0        <= 1'b0;
      A1        <= 1'b0;
      multi_err <= 1'b0;
      none_err  <= 1'b0;
      err_count <= '0;
    end else begin
      if (accept) begin
        state <= ST_FULL;
      end else if ((state == ST_FULL) && out_ready) begin
        state <= ST_EMPTY;
      end

      // Result registers load only on accept; out_valid qualifies them afterwards.
      if (accept) begin
        A1        <= code[1];
        A0        <= code[0];
        multi_err <= multi;
        none_err  <= none;
        if ((multi || none) && (err_count != ERR_MAX)) begin
          err_count <= err_count + ERR_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_encoder_4to2_reg.sv
// Directed bench for encoder_4to2_reg: a default instance, a low-priority instance
// and a 2-bit-counter instance share the same stimulus.
module tb_encoder_4to2_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] d = 4'b0000;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;

  logic       in_ready, a0, a1, out_valid, multi_err, none_err;
  logic [7:0] err_count;
  logic       lo_in_ready, lo_a0, lo_a1, lo_out_valid, lo_multi_err, lo_none_err;
  logic [7:0] lo_err_count;
  logic       st_in_ready, st_a0, st_a1, st_out_valid, st_multi_err, st_none_err;
  logic [1:0] st_err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encoder_4to2_reg #(.PRIORITY_HIGH(1'b1), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .in_valid(in_valid), .in_ready(in_ready), .A0(a0), .A1(a1),
    .out_valid(out_valid), .out_ready(out_ready),
    .multi_err(multi_err), .none_err(none_err), .err_count(err_count)
  );

  encoder_4to2_reg #(.PRIORITY_HIGH(1'b0), .ERR_CNT_W(8)) dut_lo (
    .clk(clk), .rst(rst), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .in_valid(in_valid), .in_ready(lo_in_ready), .A0(lo_a0), .A1(lo_a1),
    .out_valid(lo_out_valid), .out_ready(out_ready),
    .multi_err(lo_multi_err), .none_err(lo_none_err), .err_count(lo_err_count)
  );

  encoder_4to2_reg #(.PRIORITY_HIGH(1'b1), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
    .in_valid(in_valid), .in_ready(st_in_ready), .A0(st_a0), .A1(st_a1),
    .out_valid(st_out_valid), .out_ready(out_ready),
    .multi_err(st_multi_err), .none_err(st_none_err), .err_count(st_err_count)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] sweep_d    [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int         sweep_code [4] = '{0, 1, 2, 3};
  int         sat_exp    [5] = '{1, 2, 3, 3, 3};

  initial begin
    // Reset held for two cycles, then idle.
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_err_count", err_count, 0);
    check("rst_code", {a1, a0}, 0);
    rst = 1'b0;

    // One-hot sweep at full throughput.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = sweep_d[i];
      tick();
      check($sformatf("sweep_code_%0d", i), {a1, a0}, sweep_code[i]);
      check($sformatf("sweep_lo_code_%0d", i), {lo_a1, lo_a0}, sweep_code[i]);
      check($sformatf("sweep_valid_%0d", i), out_valid, 1);
      check($sformatf("sweep_flags_%0d", i), {multi_err, none_err}, 0);
    end
    check("sweep_err_count", err_count, 0);

    // Drain to EMPTY; the last code is held.
    in_valid = 1'b0;
    tick();
    check("drain_valid", out_valid, 0);
    check("drain_code_hold", {a1, a0}, 3);

    // Backpressure: accept 0100 into an empty slot, then stall.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    d         = 4'b0100;
    check("bp_in_ready_empty", in_ready, 1);
    tick();
    check("bp_code", {a1, a0}, 2);
    d = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_in_ready_%0d", i), in_ready, 0);
      tick();
      check($sformatf("bp_hold_%0d", i), {a1, a0}, 2);
      check($sformatf("bp_valid_%0d", i), out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_next_code", {a1, a0}, 3);

    // Error words.
    d = 4'b0110;
    tick();
    check("multi_code", {a1, a0}, 2);
    check("multi_flag", multi_err, 1);
    check("multi_none_flag", none_err, 0);
    check("multi_lo_code", {lo_a1, lo_a0}, 1);
    check("multi_lo_flag", lo_multi_err, 1);
    d = 4'b0000;
    tick();
    check("none_code", {a1, a0}, 0);
    check("none_flag", none_err, 1);
    check("none_multi_flag", multi_err, 0);
    check("err_count_two", err_count, 2);
    check("err_count_two_sat", st_err_count, 2);

    // Fresh start for the saturation run.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_err_count_sat", st_err_count, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat_count_%0d", i), st_err_count, sat_exp[i]);
    end
    check("nosat_count", err_count, 5);

    // Stall while FULL: the offered word is ignored.
    out_ready = 1'b0;
    d         = 4'b0001;
    tick();
    check("stall_ignored_code", {a1, a0}, 0);
    check("stall_ignored_none", none_err, 1);
    check("stall_sat_count", st_err_count, 3);

    // Reset mid-operation with in_valid still high.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", st_out_valid, 0);
    check("midrst_err_count", st_err_count, 0);
    check("midrst_code", {st_a1, st_a0}, 0);
    check("midrst_in_ready", st_in_ready, 1);
    check("midrst_main_count", err_count, 0);
    check("midrst_flags", {st_multi_err, st_none_err}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
